// File: rtl/lc3_mem_access_seq_pkg.sv
// lc3_pkg: shared types and constants for the LC-3 load/store access sequencer.
// Holds the sequencer state enum, the memory opcodes and the ADDR2MUX encodings,
// plus small opcode classifiers used by the control decode.
package lc3_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MAR,
        RD,
        IMAR,
        WMDR,
        WR,
        DONE
    } state_t;

    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_STR = 4'b0111;

    typedef enum logic [1:0] {
        A2_ZERO    = 2'b00,
        A2_OFF6    = 2'b01,
        A2_PCOFF9  = 2'b10,
        A2_PCOFF11 = 2'b11
    } addr2_sel_t;

    function automatic logic is_legal(input logic [3:0] op);
        return op inside {OP_LD, OP_LDI, OP_LDR, OP_ST, OP_STI, OP_STR};
    endfunction

    function automatic logic is_load(input logic [3:0] op);
        return op inside {OP_LD, OP_LDI, OP_LDR};
    endfunction

    function automatic logic is_indirect(input logic [3:0] op);
        return op inside {OP_LDI, OP_STI};
    endfunction

    // Base+offset6 addressing (LDR/STR); everything else is PC-relative.
    function automatic logic is_base_rel(input logic [3:0] op);
        return op inside {OP_LDR, OP_STR};
    endfunction

    // Stores that write straight to the computed address without a pointer read.
    function automatic logic is_direct_store(input logic [3:0] op);
        return op inside {OP_ST, OP_STR};
    endfunction

endpackage

// File: rtl/lc3_mem_access_seq_if.sv
// lc3_mem_access_seq_if: ISDU request, memory handshake and datapath control
// strobes of the LC-3 load/store sequencer. master = sequencer side.
interface lc3_mem_access_seq_if;
    logic       start;
    logic [3:0] opcode;
    logic       mem_ready;
    logic       ADDR1MUX_SELECT;
    logic [1:0] ADDR2MUX_SELECT;
    logic       GateMARMUX;
    logic       GateMDR;
    logic       GateALU;
    logic       LD_MAR;
    logic       LD_MDR;
    logic       LD_REG;
    logic       LD_CC;
    logic       MIO_EN;
    logic       MEM_WE;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        input  start, opcode, mem_ready,
        output ADDR1MUX_SELECT, ADDR2MUX_SELECT, GateMARMUX, GateMDR, GateALU,
               LD_MAR, LD_MDR, LD_REG, LD_CC, MIO_EN, MEM_WE, busy, done, err
    );

    modport slave (
        output start, opcode, mem_ready,
        input  ADDR1MUX_SELECT, ADDR2MUX_SELECT, GateMARMUX, GateMDR, GateALU,
               LD_MAR, LD_MDR, LD_REG, LD_CC, MIO_EN, MEM_WE, busy, done, err
    );
endinterface

// File: rtl/lc3_mem_access_seq_mem_wait_timer.sv
// mem_wait_timer: watchdog for a single memory access. Counts consecutive cycles
// spent waiting on mem_ready and flags expiry on the last allowed waiting cycle.
// Only instantiated when LC3_MEM_TIMEOUT_EN is defined.
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic Clk,
    input  logic Reset,
    input  logic waiting,
    output logic expired
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    assign expired = waiting && (count == LAST);

    // Count waiting cycles; any cycle not waiting restarts the count for the next access.
    always_ff @(posedge Clk) begin
        if (Reset || !waiting) begin
            count <= '0;
        end else if (!expired) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/lc3_mem_access_seq.sv
// lc3_mem_access_seq: sequences LC-3 LD/LDR/LDI/ST/STR/STI through the address
// datapath (ADDR1MUX/ADDR2MUX/MARMUX, MAR, MDR) and the memory ready handshake.
// Optional build macro LC3_MEM_TIMEOUT_EN adds a per-access mem_ready watchdog.
module lc3_mem_access_seq
    import lc3_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    lc3_mem_access_seq_if.master bus
);
    state_t     state, state_nxt;
    logic [3:0] op_q;
    logic       ind_q;
    logic       err_q;
    logic       timeout;

`ifdef LC3_MEM_TIMEOUT_EN
    logic waiting;
    assign waiting = ((state == RD) || (state == WR)) && !bus.mem_ready;

    mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_mem_wait_timer (
        .Clk     (Clk),
        .Reset   (Reset),
        .waiting (waiting),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // State register plus the per-access context: opcode, indirect pass and error.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (Reset) begin
            state <= IDLE;
            op_q  <= 4'b0000;
            ind_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q  <= bus.opcode;
                        err_q <= !is_legal(bus.opcode);
                    end
                end
                IMAR:    ind_q <= 1'b1;
                RD, WR:  if (timeout) err_q <= 1'b1;
                DONE: begin
                    ind_q <= 1'b0;
                    err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Next-state and Moore strobe decode; LD_MDR in RD follows mem_ready directly.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned,
        // which would otherwise infer a latch.
        state_nxt           = state;
        bus.ADDR1MUX_SELECT = 1'b0;
        bus.ADDR2MUX_SELECT = A2_ZERO;
        bus.GateMARMUX      = 1'b0;
        bus.GateMDR         = 1'b0;
        bus.GateALU         = 1'b0;
        bus.LD_MAR          = 1'b0;
        bus.LD_MDR          = 1'b0;
        bus.LD_REG          = 1'b0;
        bus.LD_CC           = 1'b0;
        bus.MIO_EN          = 1'b0;
        bus.MEM_WE          = 1'b0;
        bus.busy            = (state != IDLE);
        bus.done            = 1'b0;
        bus.err             = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = is_legal(bus.opcode) ? MAR : DONE;
                end
            end
            MAR: begin
                bus.ADDR1MUX_SELECT = is_base_rel(op_q);
                bus.ADDR2MUX_SELECT = is_base_rel(op_q) ? A2_OFF6 : A2_PCOFF9;
                bus.GateMARMUX      = 1'b1;
                bus.LD_MAR          = 1'b1;
                state_nxt           = is_direct_store(op_q) ? WMDR : RD;
            end
            RD: begin
                bus.MIO_EN = 1'b1;
                bus.LD_MDR = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_nxt = (!ind_q && is_indirect(op_q)) ? IMAR : DONE;
                end else if (timeout) begin
                    state_nxt = DONE;
                end
            end
            IMAR: begin
                bus.GateMDR = 1'b1;
                bus.LD_MAR  = 1'b1;
                state_nxt   = (op_q == OP_LDI) ? RD : WMDR;
            end
            WMDR: begin
                bus.GateALU = 1'b1;
                bus.LD_MDR  = 1'b1;
                state_nxt   = WR;
            end
            WR: begin
                bus.MIO_EN = 1'b1;
                bus.MEM_WE = 1'b1;
                if (bus.mem_ready || timeout) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                bus.err  = err_q;
                if (is_load(op_q) && !err_q) begin
                    bus.GateMDR = 1'b1;
                    bus.LD_REG  = 1'b1;
                    bus.LD_CC   = 1'b1;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_lc3_mem_access_seq.sv
// tb_lc3_mem_access_seq: randomized self-checking bench. Each transaction is
// expanded from its opcode and per-access memory delays into an expected
// per-cycle strobe trace, which also supplies the mem_ready drive pattern.
module tb_lc3_mem_access_seq;
    import lc3_pkg::*;

    localparam int TO = 4;

    // Expected/observed strobe word bit masks.
    localparam logic [15:0] M_A1    = 16'h0001;
    localparam logic [15:0] M_A2O6  = 16'h0002;
    localparam logic [15:0] M_A2P9  = 16'h0004;
    localparam logic [15:0] M_GMM   = 16'h0008;
    localparam logic [15:0] M_GMDR  = 16'h0010;
    localparam logic [15:0] M_GALU  = 16'h0020;
    localparam logic [15:0] M_LDMAR = 16'h0040;
    localparam logic [15:0] M_LDMDR = 16'h0080;
    localparam logic [15:0] M_LDREG = 16'h0100;
    localparam logic [15:0] M_LDCC  = 16'h0200;
    localparam logic [15:0] M_MIO   = 16'h0400;
    localparam logic [15:0] M_WE    = 16'h0800;
    localparam logic [15:0] M_BUSY  = 16'h1000;
    localparam logic [15:0] M_DONE  = 16'h2000;
    localparam logic [15:0] M_ERR   = 16'h4000;

    logic Clk = 1'b0;
    logic Reset;
    int   checks   = 0;
    int   failures = 0;

    logic [15:0] exp_q[$];
    int          rdy_q[$];
    logic [3:0]  legal_ops[6];

    always #5 Clk = ~Clk;

    lc3_mem_access_seq_if bus();

    lc3_mem_access_seq #(.TIMEOUT_CYCLES(TO)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [15:0] obs();
        return {1'b0, bus.err, bus.done, bus.busy, bus.MEM_WE, bus.MIO_EN, bus.LD_CC,
                bus.LD_REG, bus.LD_MDR, bus.LD_MAR, bus.GateALU, bus.GateMDR,
                bus.GateMARMUX, bus.ADDR2MUX_SELECT, bus.ADDR1MUX_SELECT};
    endfunction

    // rdy < 0 means the memory ready line is don't-care and is driven randomly.
    function automatic void push(input logic [15:0] word, input int rdy);
        exp_q.push_back(word);
        rdy_q.push_back(rdy);
    endfunction

    // One memory access held off for d cycles; returns 1 when the watchdog fires instead.
    function automatic bit add_wait(input logic [15:0] wait_w, input logic [15:0] ready_w, input int d);
`ifdef LC3_MEM_TIMEOUT_EN
        if (d >= TO) begin
            repeat (TO) push(wait_w, 0);
            return 1'b1;
        end
`endif
        repeat (d) push(wait_w, 0);
        push(ready_w, 1);
        return 1'b0;
    endfunction

    // Reference: expand an instruction into its expected per-cycle strobe trace.
    function automatic void build_plan(input logic [3:0] op, input int d0, input int d1);
        bit load, indirect, base, to;
        exp_q.delete();
        rdy_q.delete();
        if (!(op inside {OP_LD, OP_LDI, OP_LDR, OP_ST, OP_STI, OP_STR})) begin
            push(M_DONE | M_ERR | M_BUSY, -1);
            return;
        end
        load     = op inside {OP_LD, OP_LDI, OP_LDR};
        indirect = op inside {OP_LDI, OP_STI};
        base     = op inside {OP_LDR, OP_STR};
        to       = 1'b0;
        // Effective address: BaseR+offset6 or PC+PCoffset9 into MAR.
        push((base ? (M_A1 | M_A2O6) : M_A2P9) | M_GMM | M_LDMAR | M_BUSY, -1);
        if (load || indirect) begin
            to = add_wait(M_MIO | M_BUSY, M_MIO | M_LDMDR | M_BUSY, d0);
            if (!to && indirect) begin
                push(M_GMDR | M_LDMAR | M_BUSY, -1);
                if (op == OP_LDI) to = add_wait(M_MIO | M_BUSY, M_MIO | M_LDMDR | M_BUSY, d1);
            end
        end
        if (!to && !load) begin
            push(M_GALU | M_LDMDR | M_BUSY, -1);
            to = add_wait(M_MIO | M_WE | M_BUSY, M_MIO | M_WE | M_BUSY, (op == OP_STI) ? d1 : d0);
        end
        push(M_DONE | M_BUSY | (to ? M_ERR : (load ? (M_GMDR | M_LDREG | M_LDCC) : 16'h0)), -1);
    endfunction

    // Caller is just after a negedge with the DUT idle. abort_at >= 0 asserts
    // Reset after that trace cycle has been checked.
    task automatic run_txn(input string tag, input logic [3:0] op, input int d0, input int d1,
                           input int abort_at);
        build_plan(op, d0, d1);
        bus.start     = 1'b1;
        bus.opcode    = op;
        bus.mem_ready = 1'($urandom);
        #1 check({tag, "_idle"}, obs(), 16'h0);
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge Clk);
            bus.start     = 1'($urandom);
            bus.opcode    = 4'($urandom);
            bus.mem_ready = (rdy_q[i] < 0) ? 1'($urandom) : 1'(rdy_q[i]);
            #1 check(tag, obs(), exp_q[i]);
            if (i == abort_at) begin
                Reset = 1'b1;
                @(negedge Clk);
                Reset         = 1'b0;
                bus.start     = 1'b0;
                bus.mem_ready = 1'b1;
                #1 check({tag, "_rst"}, obs(), 16'h0);
                repeat (2) begin
                    @(negedge Clk);
                    #1 check({tag, "_rst_idle"}, obs(), 16'h0);
                end
                return;
            end
        end
        @(negedge Clk);
        bus.start     = 1'b0;
        bus.mem_ready = 1'($urandom);
    endtask

    initial begin
        int d_max;
        legal_ops = '{OP_LD, OP_LDI, OP_LDR, OP_ST, OP_STI, OP_STR};
`ifdef LC3_MEM_TIMEOUT_EN
        d_max = TO + 1;
`else
        d_max = 3;
`endif
        Reset         = 1'b1;
        bus.start     = 1'b0;
        bus.opcode    = 4'b0000;
        bus.mem_ready = 1'b0;
        repeat (2) @(negedge Clk);
        #1 check("reset_state", obs(), 16'h0);
        Reset = 1'b0;

        run_txn("ldr_ready", OP_LDR, 0, 0, -1);
        run_txn("ldi_wait3", OP_LDI, 3, 3, -1);
        run_txn("sti_ready", OP_STI, 0, 0, -1);
        run_txn("illegal",   4'b0001, 0, 0, -1);
        run_txn("st_ready",  OP_ST, 0, 0, -1);
        run_txn("str_wait",  OP_STR, 2, 0, -1);
        run_txn("ld_wait",   OP_LD, 1, 0, -1);
        // Abort in the first WR cycle of a store held off by memory.
        run_txn("st_abort",  OP_ST, 2, 0, 2);
        run_txn("after_rst", OP_LD, 0, 0, -1);
`ifdef LC3_MEM_TIMEOUT_EN
        run_txn("ld_timeout",  OP_LD, TO + 2, 0, -1);
        run_txn("sti_timeout", OP_STI, 0, TO, -1);
        run_txn("ld_edge",     OP_LD, TO - 1, 0, -1);
`endif

        for (int n = 0; n < 40; n++) begin
            logic [3:0] op;
            if ($urandom_range(0, 3) != 0) op = legal_ops[$urandom_range(0, 5)];
            else                           op = 4'($urandom);
            run_txn("rand", op, $urandom_range(0, d_max), $urandom_range(0, d_max), -1);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) begin
                    @(negedge Clk);
                    bus.start     = 1'b0;
                    bus.mem_ready = 1'($urandom);
                    #1 check("gap_idle", obs(), 16'h0);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
